// File: rtl/huffman_pkg.sv
`default_nettype none
//==========================================================================
// Module      : huffman_pkg
// Description : Shared types and constants for the per-channel entropy
//               decoder: coefficient widths, token layout, run/size codes
//               for EOB and ZRL, block length, decoder states and the
//               coefficient saturation helper.
// Config      : JPEG_DEC_ERR_EN (used by entropy_decoder)
// Revision    : 1.0 - initial release
//==========================================================================
package huffman_pkg;

   // Signed coefficient width and the widths derived from it
   localparam int DATA_WIDTH = 10;
   localparam int AMP_W      = DATA_WIDTH + 1;   // amplitude field width
   localparam int EXT_W      = DATA_WIDTH + 2;   // extended amplitude width
   // One spare bit over EXT_W so pred + largest DC difference cannot wrap
   localparam int SUM_W      = DATA_WIDTH + 3;

   // Coefficients per 8x8 block
   localparam int BLOCK_LEN = 64;

   // Special AC run/size codes
   localparam logic [3:0] EOB_RUN  = 4'd0;
   localparam logic [3:0] EOB_SIZE = 4'd0;
   localparam logic [3:0] ZRL_RUN  = 4'd15;
   localparam logic [3:0] ZRL_SIZE = 4'd0;

   // Signed coefficient limits expressed at the sum width
   localparam logic signed [SUM_W-1:0] COEF_MAX = SUM_W'((2 ** (DATA_WIDTH - 1)) - 1);
   localparam logic signed [SUM_W-1:0] COEF_MIN = SUM_W'(-(2 ** (DATA_WIDTH - 1)));

   typedef enum logic [1:0] {
      ST_DC   = 2'd0,
      ST_AC   = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   typedef struct packed {
      logic [3:0]       run;
      logic [3:0]       size;
      logic [AMP_W-1:0] amp;
   } token_t;

   // Clamp a wide signed value into the signed coefficient range
   function automatic logic signed [DATA_WIDTH-1:0] sat_coef(input logic signed [SUM_W-1:0] v);
      if (v > COEF_MAX) begin
         return COEF_MAX[DATA_WIDTH-1:0];
      end
      else if (v < COEF_MIN) begin
         return COEF_MIN[DATA_WIDTH-1:0];
      end
      return v[DATA_WIDTH-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/entropy_decoder_amp_extend.sv
`default_nettype none
//==========================================================================
// Module      : amp_extend
// Description : Combinational amplitude extension. Turns a size category
//               and right-aligned amplitude bits into a signed value; a
//               clear top bit selects the negative half of the category.
//               Sizes beyond the amplitude field decode to 0.
// Revision    : 1.0 - initial release
//==========================================================================
module amp_extend
   import huffman_pkg::*;
(
   input  logic [3:0]              size,
   input  logic [AMP_W-1:0]        amp,
   output logic signed [EXT_W-1:0] value
);

   logic [EXT_W:0] mask;
   logic [EXT_W:0] bits;

   // Mask the used amplitude bits and map them onto the signed category
   always_comb begin
      mask  = '0;
      bits  = '0;
      value = '0;
      if ((size != 4'd0) && (size <= 4'(AMP_W))) begin
         mask = (EXT_W + 1)'((32'd1 << size) - 32'd1);
         bits = (EXT_W + 1)'(amp) & mask;
         if (amp[size - 4'd1]) begin
            value = EXT_W'(bits);
         end
         else begin
            value = EXT_W'(bits - mask);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/entropy_decoder.sv
`default_nettype none
//==========================================================================
// Module      : entropy_decoder
// Description : Per-channel run-length / amplitude decoder. Accepts one
//               {run, size, amp} token per handshake and emits 64
//               coefficients per block in zigzag order, one per cycle.
//               The first token of a block is the DC difference added to
//               a running predictor; the rest are AC tokens.
// Config      : JPEG_DEC_ERR_EN - adds the sticky err output and the
//               saturation / size / overrun detection behind it.
// Revision    : 1.0 - initial release
//==========================================================================
module entropy_decoder
   import huffman_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [3:0]                   in_run,
   input  logic [3:0]                   in_size,
   input  logic [AMP_W-1:0]             in_amp,
   input  logic                         dc_clear,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic [5:0]                   out_idx,
   output logic                         out_last
`ifdef JPEG_DEC_ERR_EN
   ,
   output logic                         err
`endif
);

   state_t                       state;
   logic signed [DATA_WIDTH-1:0] pred;
   logic signed [DATA_WIDTH-1:0] pend_val;
   logic                         pend_valid;
   logic [6:0]                   pos;
   logic [6:0]                   zcnt;

   token_t                       tok;
   logic signed [EXT_W-1:0]      ext;
   logic signed [SUM_W-1:0]      ext_sx;
   logic signed [DATA_WIDTH-1:0] pred_base;
   logic signed [SUM_W-1:0]      dc_sum;
   logic signed [DATA_WIDTH-1:0] dc_val;
   logic signed [DATA_WIDTH-1:0] ac_val;
   logic                         slot_free;
   logic                         accept;
   logic                         is_eob;
   logic                         is_zrl;
   logic                         ac_big;
   logic [6:0]                   tok_zcnt;

   logic [6:0]                   src_zcnt;
   logic                         src_pend;
   logic signed [DATA_WIDTH-1:0] src_val;
   logic                         step_en;
   logic                         emit_zero;
   logic [6:0]                   nxt_zcnt;
   logic                         nxt_pend;
   logic signed [DATA_WIDTH-1:0] emit_val;
   logic                         blk_end;
   state_t                       nxt_state;

   assign tok = '{run: in_run, size: in_size, amp: in_amp};

   // One extender serves both the DC difference and the AC value
   amp_extend u_amp_extend (
      .size  (tok.size),
      .amp   (tok.amp),
      .value (ext)
   );

   // Token decode and input handshake
   always_comb begin
      slot_free = !out_valid || out_ready;
      in_ready  = !rst && ((state == ST_DC) || (state == ST_AC)) && slot_free;
      accept    = in_valid && in_ready;
      // A restart marker coinciding with the DC token applies to that token
      pred_base = dc_clear ? '0 : pred;
      ext_sx    = {{(SUM_W - EXT_W){ext[EXT_W-1]}}, ext};
      dc_sum    = {{(SUM_W - DATA_WIDTH){pred_base[DATA_WIDTH-1]}}, pred_base} + ext_sx;
      dc_val    = sat_coef(dc_sum);
      is_eob    = (tok.run == EOB_RUN) && (tok.size == EOB_SIZE);
      is_zrl    = (tok.run == ZRL_RUN) && (tok.size == ZRL_SIZE);
      ac_big    = tok.size > 4'(DATA_WIDTH);
      ac_val    = ac_big ? '0 : sat_coef(ext_sx);
      if (is_eob) begin
         tok_zcnt = 7'(BLOCK_LEN) - pos;
      end
      else if (is_zrl) begin
         tok_zcnt = 7'd16;
      end
      else begin
         tok_zcnt = {3'b000, tok.run};
      end
   end

   // One emission step: the first step of an AC token fires on its accept
   // edge so the output stream has no bubble between tokens
   always_comb begin
      if (state == ST_AC) begin
         src_zcnt = tok_zcnt;
         src_pend = !(is_eob || is_zrl);
         src_val  = ac_val;
         step_en  = accept;
      end
      else begin
         src_zcnt = zcnt;
         src_pend = pend_valid;
         src_val  = pend_val;
         step_en  = (state == ST_EMIT) && slot_free;
      end
      emit_zero = src_zcnt != 7'd0;
      nxt_zcnt  = emit_zero ? (src_zcnt - 7'd1) : src_zcnt;
      nxt_pend  = emit_zero && src_pend;
      emit_val  = emit_zero ? '0 : src_val;
      blk_end   = pos == 7'(BLOCK_LEN - 1);
      if (blk_end) begin
         nxt_state = ST_DC;
      end
      else if ((nxt_zcnt == 7'd0) && !nxt_pend) begin
         nxt_state = ST_AC;
      end
      else begin
         nxt_state = ST_EMIT;
      end
   end

   // Decoder FSM with registered output stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_DC;
         pred       <= '0;
         pos        <= '0;
         zcnt       <= '0;
         pend_valid <= 1'b0;
         pend_val   <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_idx    <= '0;
         out_last   <= 1'b0;
      end
      else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (dc_clear) begin
            pred <= '0;
         end
         if ((state == ST_DC) && accept) begin
            pred       <= dc_val;
            out_valid  <= 1'b1;
            out_data   <= dc_val;
            out_idx    <= '0;
            out_last   <= 1'b0;
            pos        <= 7'd1;
            zcnt       <= '0;
            pend_valid <= 1'b0;
            state      <= ST_AC;
         end
         if (step_en) begin
            out_valid  <= 1'b1;
            out_data   <= emit_val;
            out_idx    <= pos[5:0];
            out_last   <= blk_end;
            pos        <= pos + 7'd1;
            // Reaching idx 63 discards whatever of the token is left
            zcnt       <= blk_end ? 7'd0 : nxt_zcnt;
            pend_valid <= !blk_end && nxt_pend;
            pend_val   <= src_val;
            state      <= nxt_state;
         end
      end
   end

`ifdef JPEG_DEC_ERR_EN
   logic dc_sat;
   logic dc_big;
   logic overrun;

   // Error conditions: DC clamp, oversize categories, truncated token
   always_comb begin
      dc_sat  = (dc_sum > COEF_MAX) || (dc_sum < COEF_MIN);
      dc_big  = tok.size > 4'(AMP_W);
      overrun = blk_end && ((nxt_zcnt != 7'd0) || nxt_pend);
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end
      else if (((state == ST_DC) && accept && (dc_sat || dc_big)) ||
               ((state == ST_AC) && accept && ac_big) ||
               (step_en && overrun)) begin
         err <= 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_entropy_decoder.sv
`default_nettype none
//==========================================================================
// Module      : tb_entropy_decoder
// Description : Directed self-checking bench for entropy_decoder.
// Config      : JPEG_DEC_ERR_EN - enables the err port checks.
// Revision    : 1.0 - initial release
//==========================================================================
module tb_entropy_decoder;
   import huffman_pkg::*;

   logic                         clk       = 1'b0;
   logic                         rst       = 1'b1;
   logic                         in_valid  = 1'b0;
   logic                         dc_clear  = 1'b0;
   logic                         out_ready = 1'b1;
   logic [3:0]                   in_run    = '0;
   logic [3:0]                   in_size   = '0;
   logic [AMP_W-1:0]             in_amp    = '0;
   logic                         in_ready;
   logic                         out_valid;
   logic                         out_last;
   logic signed [DATA_WIDTH-1:0] out_data;
   logic [5:0]                   out_idx;
`ifdef JPEG_DEC_ERR_EN
   logic                         err;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int cap_n = 0;
   int base;

   logic signed [DATA_WIDTH-1:0] cap_data [512];
   logic [5:0]                   cap_idx  [512];
   logic                         cap_last [512];
   int                           cap_cyc  [512];

   entropy_decoder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_run    (in_run),
      .in_size   (in_size),
      .in_amp    (in_amp),
      .dc_clear  (dc_clear),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last)
`ifdef JPEG_DEC_ERR_EN
      ,
      .err       (err)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every accepted coefficient
   always @(negedge clk) begin
      #1;
      if (!rst && out_valid && out_ready && cap_n < 512) begin
         cap_data[cap_n] = out_data;
         cap_idx[cap_n]  = out_idx;
         cap_last[cap_n] = out_last;
         cap_cyc[cap_n]  = cyc;
         cap_n++;
      end
   end

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [3:0] r, input logic [3:0] s, input logic [AMP_W-1:0] a, input logic clr);
      int n;
      n = 0;
      in_run = r; in_size = s; in_amp = a; dc_clear = clr; in_valid = 1'b1;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         total++; bad++;
         $error("FAIL send_timeout observed=%0d expected=<300", n);
      end
      @(negedge clk);
      in_valid = 1'b0;
      dc_clear = 1'b0;
   endtask

   task automatic wait_caps(input int target);
      int n;
      n = 0;
      while (cap_n < target && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (cap_n < target) begin
         total++; bad++;
         $error("FAIL wait_caps observed=%0d expected=%0d", cap_n, target);
      end
   endtask

   // Count deviations from an all-zero run with the right idx/last flags
   function automatic int blk_err(input int b, input int from, input int to);
      int e;
      e = 0;
      for (int i = from; i <= to; i++) begin
         if (cap_data[b+i] !== '0) e++;
         if (cap_idx[b+i] !== 6'(i)) e++;
         if (cap_last[b+i] !== (i == 63)) e++;
      end
      return e;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_out_last", out_last, 0);
`ifdef JPEG_DEC_ERR_EN
      check("rst_err", err, 0);
`endif
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", in_ready, 1);

      // Block 1: DC +5 then EOB
      send(4'd0, 4'd3, 11'b101, 1'b0);
      send(4'd0, 4'd0, 11'd0, 1'b0);
      wait_caps(64);
      check("b1_dc", cap_data[0], 5);
      check("b1_idx0", cap_idx[0], 0);
      check("b1_zeros", blk_err(0, 1, 63), 0);
      check("b1_span", cap_cyc[63] - cap_cyc[0], 63);

      // Block 2: DC diff -2 -> 3
      send(4'd0, 4'd2, 11'b01, 1'b0);
      send(4'd0, 4'd0, 11'd0, 1'b0);
      wait_caps(128);
      check("b2_dc", cap_data[64], 3);
      check("b2_zeros", blk_err(64, 1, 63), 0);

      // Block 3: dc_clear with DC +1, then run 2 value -5
      send(4'd0, 4'd1, 11'b1, 1'b1);
      send(4'd2, 4'd3, 11'b010, 1'b0);
      check("b3_ready_idx1", in_ready, 0);
      check("b3_out_idx1", out_idx, 1);
      @(negedge clk);
      check("b3_ready_idx2", in_ready, 0);
      @(negedge clk);
      check("b3_ready_idx3", in_ready, 1);
      check("b3_out_idx3", out_idx, 3);
      check("b3_out_data3", out_data, -5);
      send(4'd0, 4'd0, 11'd0, 1'b0);
      wait_caps(192);
      check("b3_dc_cleared", cap_data[128], 1);
      check("b3_run_zeros", blk_err(128, 1, 2), 0);
      check("b3_val", cap_data[131], -5);
      check("b3_val_idx", cap_idx[131], 3);
      check("b3_tail", blk_err(128, 4, 63), 0);

      // Block 4: DC diff 0, ZRL x3, run 14 value +1 at idx 63
      send(4'd0, 4'd0, 11'd0, 1'b0);
      repeat (3) send(4'd15, 4'd0, 11'd0, 1'b0);
      send(4'd14, 4'd1, 11'd1, 1'b0);
      wait_caps(256);
      check("b4_dc", cap_data[192], 1);
      check("b4_zeros", blk_err(192, 1, 62), 0);
      check("b4_last_val", cap_data[255], 1);
      check("b4_last_idx", cap_idx[255], 63);
      check("b4_last_flag", cap_last[255], 1);

      // Block 5: next token is DC (+3 -> 4), then overrun at pos 60
      send(4'd0, 4'd2, 11'b11, 1'b0);
      repeat (3) send(4'd15, 4'd0, 11'd0, 1'b0);
      send(4'd10, 4'd1, 11'd1, 1'b0);
`ifdef JPEG_DEC_ERR_EN
      check("b5_err_before", err, 0);
`endif
      send(4'd15, 4'd1, 11'd1, 1'b0);
      wait_caps(320);
      repeat (3) @(negedge clk);
      check("b5_dc", cap_data[256], 4);
      check("b5_zeros", blk_err(256, 1, 58), 0);
      check("b5_val", cap_data[315], 1);
      check("b5_val_idx", cap_idx[315], 59);
      check("b5_trunc", blk_err(256, 60, 63), 0);
      check("b5_count", cap_n, 320);
`ifdef JPEG_DEC_ERR_EN
      check("b5_err_after", err, 1);
`endif

      // Block 6: backpressure mid zero-run, then reset mid-block
      send(4'd0, 4'd1, 11'b1, 1'b0);
      send(4'd0, 4'd0, 11'd0, 1'b0);
      repeat (3) @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_idx", out_idx, 4);
         check("bp_data", out_data, 0);
         check("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_resume_idx", out_idx, 5);
      check("b6_dc", cap_data[320], 5);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_idx", out_idx, 0);
      check("mid_rst_last", out_last, 0);
      check("mid_rst_in_ready", in_ready, 0);
`ifdef JPEG_DEC_ERR_EN
      check("mid_rst_err", err, 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      base = cap_n;
      send(4'd0, 4'd3, 11'b101, 1'b0);
      wait_caps(base + 1);
      check("post_rst_dc", cap_data[base], 5);
      check("post_rst_idx", cap_idx[base], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
